// File: rtl/uart_rx_if.sv
// Byte-output channel of the UART receiver: data handshake plus one-cycle error pulses.
// master = receiver side, slave = consumer side.
interface uart_rx_if;
    // Handshake: o_valid stays high and o_data stays stable until the cycle
    // where o_valid && i_ready, which is the transfer. A new byte may load in
    // that same transfer cycle. o_valid never depends on i_ready combinationally.
    logic       o_valid;
    logic [7:0] o_data;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_parity_err;
    logic       o_overrun;

    modport master (
        output o_valid, o_data, o_frame_err, o_parity_err, o_overrun,
        input  i_ready
    );

    modport slave (
        input  o_valid, o_data, o_frame_err, o_parity_err, o_overrun,
        output i_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, optional even parity (UART_RX_PARITY_EN), 1 stop bit,
// CLK_DIV clocks per bit, byte presented on a valid/ready channel with error pulses.
module uart_rx #(
    parameter int CLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx,
    uart_rx_if.master   bus,
    output logic [2:0]  state_dbg
);
    localparam int CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_PARITY = 3'd3, S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2,
        S_STOP = 3'd4, S_WAIT_HIGH = 3'd5
    } state_t;
`endif

    state_t          state, state_next;
    logic            sync1, rx_s;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      idx, idx_next;
    logic [7:0]      shreg;
    logic            shift_en, deliver, frame_set;
    logic            valid_q, fe_q, ov_q;
    logic [7:0]      data_q;

`ifdef UART_RX_PARITY_EN
    logic            par_bit, par_load, parity_set, pe_q, par_bad;
    assign par_bad = ^{shreg, par_bit};
`endif

    // rx is asynchronous; the line idles high so the synchroniser resets high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + CW'(1);
        idx_next   = idx;
        shift_en   = 1'b0;
        deliver    = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_load   = 1'b0;
        parity_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_next = '0;
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (cnt == HALF) begin
                    cnt_next   = '0;
                    idx_next   = 3'd0;
                    state_next = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == LAST) begin
                    cnt_next = '0;
                    shift_en = 1'b1;
                    idx_next = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = S_PARITY;
`else
                        state_next = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == LAST) begin
                    cnt_next   = '0;
                    par_load   = 1'b1;
                    state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt == LAST) begin
                    cnt_next = '0;
                    if (!rx_s) begin
                        // Frame error wins over parity error.
                        frame_set  = 1'b1;
                        state_next = S_WAIT_HIGH;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        parity_set = 1'b1;
                        state_next = S_IDLE;
`endif
                    end else begin
                        deliver    = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                cnt_next = '0;
                if (rx_s) state_next = S_IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= 3'd0;
            shreg <= 8'h00;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
            if (shift_en) shreg <= {rx_s, shreg[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bit <= 1'b0;
            pe_q    <= 1'b0;
        end else begin
            if (par_load) par_bit <= rx_s;
            pe_q <= parity_set;
        end
    end
    assign bus.o_parity_err = pe_q;
`else
    assign bus.o_parity_err = 1'b0;
`endif

    // A delivered byte may replace the held one only when it is being consumed this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            fe_q <= frame_set;
            ov_q <= 1'b0;
            if (deliver) begin
                if (!valid_q || bus.i_ready) begin
                    valid_q <= 1'b1;
                    data_q  <= shreg;
                end else begin
                    ov_q <= 1'b1;
                end
            end else if (valid_q && bus.i_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_valid     = valid_q;
    assign bus.o_data      = data_q;
    assign bus.o_frame_err = fe_q;
    assign bus.o_overrun   = ov_q;
    assign state_dbg       = state;
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at CLK_DIV=4: frame-level event model checked every cycle,
// plus literal spot checks at the expected completion cycles.
module tb_uart_rx;
    localparam int D = 4;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Cycles from first capture of the start bit to the result.
    localparam int LAT = 3 + D / 2 + 9 * D + PBITS * D;
    localparam int K_DATA = 0, K_FRAME = 1, K_PAR = 2;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [2:0] state_dbg;

    uart_rx_if bus();

    uart_rx #(.CLK_DIV(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    ev_t        ev_q[$];
    int         cyc   = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic       m_valid = 1'b0;
    logic [7:0] m_data  = 8'h00;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, got, want);
        end
    endtask

    // Per-cycle model: each frame yields one result at a known cycle; the
    // handshake decides whether a data result loads, overruns, or a held byte drains.
    initial begin : scoreboard
        logic rdy, rs, fe, pe, ov, consumed, load;
        ev_t  ev;
        forever begin
            @(posedge clk);
            cyc++;
            rdy = bus.i_ready;
            rs  = rst;
            #1;
            fe = 1'b0; pe = 1'b0; ov = 1'b0; load = 1'b0;
            if (rs) begin
                m_valid = 1'b0;
                m_data  = 8'h00;
                ev_q.delete();
            end else begin
                consumed = m_valid && rdy;
                if (ev_q.size() != 0 && ev_q[0].at == cyc) begin
                    ev = ev_q.pop_front();
                    case (ev.kind)
                        K_DATA:  if (!m_valid || rdy) load = 1'b1; else ov = 1'b1;
                        K_FRAME: fe = 1'b1;
                        default: pe = 1'b1;
                    endcase
                end
                if (load) begin
                    m_valid = 1'b1;
                    m_data  = ev.data;
                end else if (consumed) begin
                    m_valid = 1'b0;
                end
            end
            check("outputs",
                  {3'b000, bus.o_valid, bus.o_data, bus.o_frame_err, bus.o_parity_err, bus.o_overrun},
                  {3'b000, m_valid, m_data, fe, pe, ov});
        end
    end

    // Called at a falling edge; returns at the falling edge that ends the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic pflip, output int e);
        int kind;
        e = cyc + 1;
        if (!stop)                    kind = K_FRAME;
        else if (PBITS != 0 && pflip) kind = K_PAR;
        else                          kind = K_DATA;
        ev_q.push_back('{e + LAT, kind, d});
        rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (D) @(negedge clk);
        end
        if (PBITS != 0) begin
            rx = (^d) ^ pflip;
            repeat (D) @(negedge clk);
        end
        rx = stop;
        repeat (D) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cyc(input int at);
        if (cyc >= at) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_cyc: cycle %0d already past %0d", cyc, at);
        end
        while (cyc < at) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin : main
        int e1, e2;
        logic [7:0] d;
        bus.i_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", bus.o_valid, 1'b0);
        check("reset_data", bus.o_data, 8'h00);
        check("reset_state", state_dbg, 3'd0);
        rst = 1'b0;
        idle(4);

        // Single byte, consumer always ready: one-cycle valid.
        send_frame(8'h41, 1'b1, 1'b0, e1);
        wait_cyc(e1 + LAT - 1);
        check("valid_before_latency", bus.o_valid, 1'b0);
        wait_cyc(e1 + LAT);
        check("byte_41_valid", bus.o_valid, 1'b1);
        check("byte_41_data", bus.o_data, 8'h41);
        wait_cyc(e1 + LAT + 1);
        check("byte_41_valid_drop", bus.o_valid, 1'b0);
        @(negedge clk);
        idle(8);

        // One-cycle glitch low must not start a frame.
        rx = 1'b0;
        @(negedge clk);
        idle(3 * D);
        check("glitch_state_idle", state_dbg, 3'd0);

        // Bad stop bit followed by a long break, then a clean frame.
        send_frame(8'hA5, 1'b0, 1'b0, e1);
        wait_cyc(e1 + LAT);
        check("frame_err_pulse", bus.o_frame_err, 1'b1);
        check("frame_err_no_valid", bus.o_valid, 1'b0);
        @(negedge clk);
        rx = 1'b0;
        repeat (20 * D) @(negedge clk);
        idle(2 * D);
        send_frame(8'h3C, 1'b1, 1'b0, e2);
        wait_cyc(e2 + LAT);
        check("byte_3c_data", bus.o_data, 8'h3C);
        @(negedge clk);
        idle(4);

        // Stalled consumer, back-to-back frames: second byte is dropped.
        bus.i_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, e1);
        send_frame(8'h22, 1'b1, 1'b0, e2);
        wait_cyc(e2 + LAT);
        check("overrun_pulse", bus.o_overrun, 1'b1);
        check("overrun_held_data", bus.o_data, 8'h11);
        wait_cyc(e2 + LAT + 1);
        check("overrun_one_cycle", bus.o_overrun, 1'b0);
        check("overrun_still_valid", bus.o_valid, 1'b1);
        @(negedge clk);
        bus.i_ready = 1'b1;
        idle(4);
        check("drained_valid", bus.o_valid, 1'b0);

        // Reset during data bit 4, then a fresh frame.
        d = 8'h7E;
        rx = 1'b0;
        repeat (D) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            repeat (D) @(negedge clk);
        end
        rx = d[4];
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_reset_valid", bus.o_valid, 1'b0);
        check("midframe_reset_state", state_dbg, 3'd0);
        repeat (4) @(negedge clk);
        rx  = 1'b1;
        rst = 1'b0;
        idle(3 * D);
        send_frame(8'h7E, 1'b1, 1'b0, e1);
        wait_cyc(e1 + LAT);
        check("byte_7e_data", bus.o_data, 8'h7E);
        @(negedge clk);
        idle(4);

`ifdef UART_RX_PARITY_EN
        // 8'h03 has even bit count, so a parity bit of 1 is wrong.
        send_frame(8'h03, 1'b1, 1'b1, e1);
        wait_cyc(e1 + LAT);
        check("parity_err_pulse", bus.o_parity_err, 1'b1);
        check("parity_err_no_valid", bus.o_valid, 1'b0);
        @(negedge clk);
        idle(4);
        send_frame(8'h03, 1'b1, 1'b0, e1);
        wait_cyc(e1 + LAT);
        check("byte_03_data", bus.o_data, 8'h03);
        @(negedge clk);
        idle(4);
`endif

        idle(10);
        check("all_results_seen", ev_q.size(), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Standalone UART receiver, the receive-side counterpart to the `uart` transmit path. It deserialises 8N1 frames from the asynchronous `rx` pin into bytes and presents each byte on a valid/ready output. It sits beside the transmitter in the CPU's serial peripheral and shares its `CLK_DIV` bit-period convention, so the two ends interoperate at the same baud rate.

## Interface
- `CLK_DIV`, default 2: clk cycles per bit period; legal values are 2 and above.
- `clk` input, 1 bit: single clock; all state is updated on its rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `rx` input, 1 bit: serial line; idles high; asynchronous to `clk`.
- `o_valid` output, 1 bit: `o_data` holds an unconsumed byte.
- `o_data` output, 8 bits: received byte, LSB-first on the wire.
- `i_ready` input, 1 bit: consumer accepts the byte when `o_valid && i_ready`.
- `o_frame_err` output, 1 bit: one-cycle pulse when the stop bit is sampled low.
- `o_parity_err` output, 1 bit: one-cycle pulse on parity mismatch; tied 0 when parity is compiled out.
- `o_overrun` output, 1 bit: one-cycle pulse when a completed byte is dropped.

## Operation
- `rx` passes through a 2-flop synchroniser, reset to 1. Call the synchronised value `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY (only when parity is compiled in), STOP, WAIT_HIGH.
- IDLE: when `rx_s` is 0, load the counter with 0 and enter START.
- START: sample at count `CLK_DIV/2` (floor).
  - If `rx_s` is 1, it was a false start; return to IDLE with no output activity.
  - Otherwise clear the counter and the bit index, then enter DATA.
- DATA: sample `rx_s` every `CLK_DIV` cycles and shift it into the MSB of the shift register (LSB arrives first). After the 8th sample, go to PARITY if compiled in, else STOP.
- PARITY: sample `CLK_DIV` cycles after bit 7. Parity is even: the XOR of the 8 data bits and the parity bit must be 0. Go to STOP.
- STOP: sample `CLK_DIV` cycles after the previous sample.
  - `rx_s` = 1 and no parity error: the byte is delivered per the handshake rules below; go to IDLE.
  - `rx_s` = 0: pulse `o_frame_err`, discard the byte, go to WAIT_HIGH. A frame error takes priority over a parity error; in that case only `o_frame_err` pulses.
  - Parity error with a good stop bit: pulse `o_parity_err`, discard the byte, go to IDLE.
- WAIT_HIGH: stay until `rx_s` is 1, then go to IDLE. This prevents a held-low line (break) from retriggering START.
- Handshake, evaluated at the cycle a byte is delivered:
  - `o_valid` low: load `o_data` and set `o_valid`.
  - `o_valid` high and `i_ready` high in the same cycle: the old byte is consumed, the new byte is loaded, and `o_valid` stays 1. No overrun.
  - `o_valid` high and `i_ready` low: keep the old byte, drop the new one, pulse `o_overrun`.
- `o_valid` falls on the cycle after `o_valid && i_ready` when no new byte arrives. `o_data` is stable while `o_valid` is 1.
- Counter width is `$clog2(CLK_DIV)+1` bits. It resets to 0 at each sample point; there is no wrap-around between samples.

## Timing
- Reset values: `o_valid`=0, `o_data`=8'h00, `o_frame_err`=0, `o_parity_err`=0, `o_overrun`=0. The FSM resets to IDLE and the synchroniser to 1.
- Reset asserted mid-frame aborts immediately with no error pulse. The first frame after reset release requires a fresh falling edge on `rx_s`.
- Latency, with E = the clk edge at which the first sync flop captures the low start bit:
  - `o_valid` rises at E + 3 + `CLK_DIV/2` + 9·`CLK_DIV` cycles.
  - With parity compiled in, add `CLK_DIV`.
- Error pulses and `o_overrun` assert at the same cycle `o_valid` would have risen.
- Back-to-back frames: a start bit immediately following the stop bit is accepted. The receiver is back in IDLE half a bit into the stop bit.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is start, 8 data, even parity, stop. The PARITY state exists and `o_parity_err` is live.
- `UART_RX_PARITY_EN` undefined: frame is 8N1. There is no PARITY state and `o_parity_err` is constant 0.

## Test plan
All scenarios use `CLK_DIV`=4 with parity compiled out, except the last, which enables parity.
- Send 8'h41 with `i_ready`=1: `o_valid` pulses for 1 cycle with `o_data`=8'h41 at E+41. No error pulses.
- Drive `rx` low for 1 cycle, then high: no START completes, and `o_valid`, `o_frame_err` and `o_overrun` all stay 0.
- Send 8'hA5 with the stop bit low, hold `rx` low for 20 bits, then release and send 8'h3C: `o_frame_err` pulses once, then `o_data`=8'h3C is delivered.
- With `i_ready`=0, send 8'h11 then 8'h22 back-to-back: `o_data`=8'h11 is held, `o_overrun` pulses once at the second byte's completion, and `o_data` stays 8'h11.
- Assert `rst` during bit 4 of a frame, release, then send 8'h7E: outputs are 0 during reset, there is no spurious byte, and 8'h7E is then received.
- With `UART_RX_PARITY_EN` defined, send 8'h03 with parity 1: `o_parity_err` pulses and `o_valid` stays 0. Resend with parity 0: `o_data`=8'h03.
